soc_reset_sequencer: RTL
========================

// Module: soc_reset_sequencer
// PURPOSE
// Board-level reset controller between the PLL and matrix_accelerator_soc.
// Gates reset release on a stable PLL lock and a debounced reset button.
// Releases the HBM clock domain reset first and the core reset a fixed time later.
// On lock loss or a button press, re-asserts both resets and restarts the sequence.
// PARAMETERS
// SYNC_STAGES         2     synchronizer flops on locked_i and btn_i (>=2)
// DEBOUNCE_CYCLES     1000  cycles btn_i must be stable before the debounced value changes
// ASSERT_CYCLES       16    minimum cycles both resets stay asserted in S_ASSERT
// LOCK_STABLE_CYCLES  64    consecutive synced-lock cycles required before HBM release
// HBM_TO_CORE_CYCLES  32    cycles from rst_n_hbm rising to rst_n_core rising
// PORTS
// clk          in   1  system clock (PLL clk_out100)
// rst          in   1  synchronous, active-high reset of this block
// locked_i     in   1  PLL locked, asynchronous
// btn_i        in   1  board reset button, active-high when pressed, asynchronous
// rst_n_hbm    out  1  active-low reset for the clk_hbm domain
// rst_n_core   out  1  active-low reset for the SoC core
// ready_o      out  1  1 when the sequence is complete (S_RUN)
// state_o      out  3  current FSM state encoding
// lock_loss_o  out  8  count of lock losses after HBM release; saturates at 255
// BEHAVIOUR
// - Reset (rst=1 at a clk edge):
//   - state=S_ASSERT; rst_n_hbm=0, rst_n_core=0, ready_o=0, lock_loss_o=0.
//   - All counters, sync flops and the debounced button clear to 0.
// - Input conditioning:
//   - locked_s and btn_s are SYNC_STAGES-deep flop chains.
//   - btn_db follows btn_s only after btn_s differs from btn_db for DEBOUNCE_CYCLES consecutive cycles.
//   - The stability counter clears whenever btn_s equals btn_db.
// - All outputs are registered. ready_o = (state==S_RUN).
// - FSM encoding: S_ASSERT=0, S_LOCK_WAIT=1, S_REL_HBM=2, S_RUN=3; values 4-7 are illegal and go to S_ASSERT.
// - S_ASSERT: rst_n_hbm=0, rst_n_core=0.
//   - cnt increments each cycle btn_db=0; cnt clears while btn_db=1.
//   - When cnt==ASSERT_CYCLES-1 and btn_db=0, go to S_LOCK_WAIT with cnt=0.
// - S_LOCK_WAIT: cnt increments while locked_s=1 and clears when locked_s=0.
//   - When cnt==LOCK_STABLE_CYCLES-1 and locked_s=1, go to S_REL_HBM; rst_n_hbm=1 on that same edge; cnt=0.
// - S_REL_HBM: cnt increments.
//   - When cnt==HBM_TO_CORE_CYCLES-1, go to S_RUN; rst_n_core=1 on that same edge.
// - S_RUN: hold until a fault.
// - Fault (any state except S_ASSERT): locked_s=0 or btn_db=1.
//   - Next edge: state=S_ASSERT, cnt=0, rst_n_hbm=0, rst_n_core=0.
//   - In S_LOCK_WAIT, locked_s=0 only clears cnt; btn_db=1 is a fault.
// - lock_loss_o increments, saturating, when locked_s=0 causes a fault from S_REL_HBM or S_RUN.
//   - A fault caused by btn_db alone does not increment it.
//   - If both fault causes occur in the same cycle, it increments once.
// - Invariant: rst_n_core=1 implies rst_n_hbm=1 on every cycle. Both fall on the same edge.
// - Counter widths: $clog2 of the largest parameter, plus 1.
// TESTING
// Parameters for the directed tests: SYNC=2, DEBOUNCE=4, ASSERT=4, LOCK_STABLE=8, HBM_TO_CORE=6.
// Edge 1 is the first clk edge with rst=0.
// 1. locked_i=1 held from before rst release, btn_i=0 -> S_LOCK_WAIT after edge 4;
//    rst_n_hbm=1 after edge 12; rst_n_core=1 and ready_o=1 after edge 18.
// 2. From S_RUN, drop locked_i for 1 cycle -> 3 edges later both resets are 0, state=0,
//    lock_loss_o=1; full sequence replays with identical spacing.
// 3. btn_i glitch high for 3 cycles in S_RUN -> no change;
//    btn_i high for 6 cycles -> both resets fall 2+4+1 edges after the press,
//    lock_loss_o unchanged, sequence restarts after release plus debounce.
// 4. In S_LOCK_WAIT, toggle locked_i low at cnt=5 -> cnt restarts;
//    rst_n_hbm rises only after 8 further consecutive locked_s cycles.
// 5. Force 300 lock losses from S_RUN -> lock_loss_o saturates at 255.
//    Assert rst mid-S_REL_HBM -> all outputs return to reset values on the next edge.
// 6. Random locked_i/btn_i for 100k cycles -> assertion rst_n_core |-> rst_n_hbm never fires.

Source files
------------

// File: rtl/soc_reset_sequencer.sv
// Board-level reset sequencer: conditions PLL lock and the reset button, then releases
// the HBM domain reset followed by the core reset, restarting on any fault.
module soc_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int DEBOUNCE_CYCLES    = 1000,
   parameter int ASSERT_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES = 64,
   parameter int HBM_TO_CORE_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       locked_i,
   input  logic       btn_i,
   output logic       rst_n_hbm,
   output logic       rst_n_core,
   output logic       ready_o,
   output logic [2:0] state_o,
   output logic [7:0] lock_loss_o
);

   typedef enum logic [2:0] {
      S_ASSERT    = 3'd0,
      S_LOCK_WAIT = 3'd1,
      S_REL_HBM   = 3'd2,
      S_RUN       = 3'd3
   } state_t;

   localparam int MAX_AB = (DEBOUNCE_CYCLES > ASSERT_CYCLES) ? DEBOUNCE_CYCLES : ASSERT_CYCLES;
   localparam int MAX_CD = (LOCK_STABLE_CYCLES > HBM_TO_CORE_CYCLES) ? LOCK_STABLE_CYCLES : HBM_TO_CORE_CYCLES;
   localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = $clog2(MAX_P) + 1;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [CW-1:0]          db_cnt_q, db_cnt_d;
   logic [SYNC_STAGES-1:0] locked_sync_q, locked_sync_d;
   logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
   logic                   btn_db_q, btn_db_d;
   logic                   rst_n_hbm_q, rst_n_hbm_d;
   logic                   rst_n_core_q, rst_n_core_d;
   logic                   ready_q, ready_d;
   logic [7:0]             lock_loss_q, lock_loss_d;
   logic                   locked_s, btn_s, fault;

   assign locked_s = locked_sync_q[SYNC_STAGES-1];
   assign btn_s    = btn_sync_q[SYNC_STAGES-1];

   // The debounced button only flips after btn_s has disagreed with it for the full window.
   always_comb begin
      locked_sync_d = {locked_sync_q[SYNC_STAGES-2:0], locked_i};
      btn_sync_d    = {btn_sync_q[SYNC_STAGES-2:0], btn_i};
      btn_db_d      = btn_db_q;
      db_cnt_d      = '0;
      if (btn_s != btn_db_q) begin
         if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = btn_s;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lock_loss_d = lock_loss_q;
      fault       = 1'b0;
      case (state_q)
         S_ASSERT: begin
            if (btn_db_q) begin
               cnt_d = '0;
            end else if (cnt_q == CW'(ASSERT_CYCLES - 1)) begin
               state_d = S_LOCK_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // A lock drop here merely restarts the stability window.
         S_LOCK_WAIT: begin
            if (btn_db_q) begin
               fault = 1'b1;
            end else if (!locked_s) begin
               cnt_d = '0;
            end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
               state_d = S_REL_HBM;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REL_HBM: begin
            if (btn_db_q || !locked_s) begin
               fault = 1'b1;
            end else if (cnt_q == CW'(HBM_TO_CORE_CYCLES - 1)) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (btn_db_q || !locked_s) begin
               fault = 1'b1;
            end
         end
         default: begin
            state_d = S_ASSERT;
            cnt_d   = '0;
         end
      endcase
      if (fault) begin
         state_d = S_ASSERT;
         cnt_d   = '0;
      end
      if (!locked_s && (state_q == S_REL_HBM || state_q == S_RUN) && lock_loss_q != 8'hFF) begin
         lock_loss_d = lock_loss_q + 8'd1;
      end
      rst_n_hbm_d  = (state_d == S_REL_HBM) || (state_d == S_RUN);
      rst_n_core_d = (state_d == S_RUN);
      ready_d      = (state_d == S_RUN);
   end

   // Outputs derive from the next state, so both resets fall on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_ASSERT;
         cnt_q         <= '0;
         db_cnt_q      <= '0;
         locked_sync_q <= '0;
         btn_sync_q    <= '0;
         btn_db_q      <= 1'b0;
         rst_n_hbm_q   <= 1'b0;
         rst_n_core_q  <= 1'b0;
         ready_q       <= 1'b0;
         lock_loss_q   <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         db_cnt_q      <= db_cnt_d;
         locked_sync_q <= locked_sync_d;
         btn_sync_q    <= btn_sync_d;
         btn_db_q      <= btn_db_d;
         rst_n_hbm_q   <= rst_n_hbm_d;
         rst_n_core_q  <= rst_n_core_d;
         ready_q       <= ready_d;
         lock_loss_q   <= lock_loss_d;
      end
   end

   assign rst_n_hbm   = rst_n_hbm_q;
   assign rst_n_core  = rst_n_core_q;
   assign ready_o     = ready_q;
   assign state_o     = state_q;
   assign lock_loss_o = lock_loss_q;

endmodule
